seq_divider: RTL and testbench

- Parametrised multicycle integer divider for the multdiv unit; next generation of the fixed-width 32-bit divider.
- Adds: WIDTH parameter, signed/unsigned mode, remainder output, real divide-by-zero and signed-overflow exceptions, busy flag, restart-on-start, synchronous reset.
- Computes one quotient bit per cycle using non-restoring shift/add-sub on a 2*WIDTH+1 remainder:quotient register, followed by one sign-fix-up cycle.

---
 rtl/seq_divider.sv | 171 +++++++++++++++++
 tb/tb_seq_divider.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/seq_divider.sv
// seq_divider: multicycle signed/unsigned integer divider, one quotient bit per cycle.
// Uses non-restoring shift/add-sub on a {remainder, quotient} register, then one
// sign fix-up cycle. Divide-by-zero and signed overflow finish in one cycle.
// Ports:
//   clock, reset      rising-edge clock, synchronous active-high reset
//   ctrl_DIV          start pulse; operands and ctrl_signed sampled on the same edge
//   data_operandA/B   dividend / divisor (WIDTH bits)
//   ctrl_signed       1 = two's-complement operands, 0 = unsigned
//   data_result       quotient (truncated toward zero)
//   data_remainder    remainder (takes the dividend's sign)
//   data_exception    divide-by-zero or signed overflow, valid with data_resultRDY
//   data_resultRDY    one-cycle done pulse
//   busy              high while an operation is in flight
module seq_divider #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_DIV,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic             ctrl_signed,
  output logic [WIDTH-1:0] data_result,
  output logic [WIDTH-1:0] data_remainder,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam int unsigned AW = 2 * WIDTH + 1;
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [AW-1:0]    acc_q, acc_d;
  logic [WIDTH-1:0] dvsr_q, dvsr_d;
  logic             negq_q, negq_d;
  logic             negr_q, negr_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             exc_q, exc_d;
  logic             rdy_q, rdy_d;
  logic             busy_q, busy_d;

  // Operand magnitudes and special-case detection at the start edge.
  logic             a_neg, b_neg, div0, ovf;
  logic [WIDTH-1:0] a_mag, b_mag;

  assign a_neg = ctrl_signed & data_operandA[WIDTH-1];
  assign b_neg = ctrl_signed & data_operandB[WIDTH-1];
  assign a_mag = a_neg ? (~data_operandA + WIDTH'(1)) : data_operandA;
  assign b_mag = b_neg ? (~data_operandB + WIDTH'(1)) : data_operandB;
  assign div0  = (data_operandB == '0);
  assign ovf   = ctrl_signed && (data_operandA == MIN_VAL) && (&data_operandB);

  // One non-restoring step: shift left, add or subtract by previous sign,
  // quotient bit is the inverted sign of the new partial remainder.
  logic [WIDTH:0]   up_sh, up_new;
  logic [AW-1:0]    step_acc;

  assign up_sh    = acc_q[AW-2:WIDTH-1];
  assign up_new   = acc_q[AW-1] ? (up_sh + {1'b0, dvsr_q}) : (up_sh - {1'b0, dvsr_q});
  assign step_acc = {up_new, acc_q[WIDTH-2:0], ~up_new[WIDTH]};

  // Fix-up: restore a negative final remainder, then apply result signs.
  // The corrected remainder lies in [0, |B|), so WIDTH-bit arithmetic suffices.
  logic [WIDTH-1:0] rem_mag, quo_mag, quo_fix, rem_fix;

  assign rem_mag = acc_q[AW-1] ? (acc_q[AW-2:WIDTH] + dvsr_q) : acc_q[AW-2:WIDTH];
  assign quo_mag = acc_q[WIDTH-1:0];
  assign quo_fix = negq_q ? (~quo_mag + WIDTH'(1)) : quo_mag;
  assign rem_fix = negr_q ? (~rem_mag + WIDTH'(1)) : rem_mag;

  // State and datapath registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      dvsr_q   <= '0;
      negq_q   <= 1'b0;
      negr_q   <= 1'b0;
      result_q <= '0;
      rem_q    <= '0;
      exc_q    <= 1'b0;
      rdy_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      dvsr_q   <= dvsr_d;
      negq_q   <= negq_d;
      negr_q   <= negr_d;
      result_q <= result_d;
      rem_q    <= rem_d;
      exc_q    <= exc_d;
      rdy_q    <= rdy_d;
      busy_q   <= busy_d;
    end
  end

  // Next-state and next-output logic; a start aborts anything in flight.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    dvsr_d   = dvsr_q;
    negq_d   = negq_q;
    negr_d   = negr_q;
    result_d = result_q;
    rem_d    = rem_q;
    exc_d    = exc_q;
    rdy_d    = 1'b0;
    busy_d   = 1'b0;

    if (ctrl_DIV) begin
      cnt_d    = '0;
      result_d = '0;
      rem_d    = '0;
      exc_d    = 1'b0;
      if (div0) begin
        state_d = DONE;
        exc_d   = 1'b1;
        rem_d   = data_operandA;
        rdy_d   = 1'b1;
      end else if (ovf) begin
        state_d  = DONE;
        exc_d    = 1'b1;
        result_d = MIN_VAL;
        rdy_d    = 1'b1;
      end else begin
        state_d = RUN;
        acc_d   = {{(WIDTH+1){1'b0}}, a_mag};
        dvsr_d  = b_mag;
        negq_d  = a_neg ^ b_neg;
        negr_d  = a_neg;
        busy_d  = 1'b1;
      end
    end else begin
      case (state_q)
        IDLE: state_d = IDLE;
        RUN: begin
          acc_d  = step_acc;
          cnt_d  = cnt_q + CW'(1);
          busy_d = 1'b1;
          if (cnt_q == CW'(WIDTH - 1)) state_d = FIX;
        end
        FIX: begin
          result_d = quo_fix;
          rem_d    = rem_fix;
          exc_d    = 1'b0;
          rdy_d    = 1'b1;
          state_d  = DONE;
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  assign data_result    = result_q;
  assign data_remainder = rem_q;
  assign data_exception = exc_q;
  assign data_resultRDY = rdy_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: directed and random checks of seq_divider (WIDTH=32) against
// an arithmetic reference model (native / and % on 64-bit signed integers).
module tb_seq_divider;

  localparam int unsigned W = 32;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         ctrl_DIV = 1'b0;
  logic [W-1:0] data_operandA = '0;
  logic [W-1:0] data_operandB = '0;
  logic         ctrl_signed = 1'b0;
  logic [W-1:0] data_result;
  logic [W-1:0] data_remainder;
  logic         data_exception;
  logic         data_resultRDY;
  logic         busy;

  int nvec = 0;
  int nfail = 0;

  seq_divider #(.WIDTH(W)) dut (
    .clock          (clock),
    .reset          (reset),
    .ctrl_DIV       (ctrl_DIV),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .ctrl_signed    (ctrl_signed),
    .data_result    (data_result),
    .data_remainder (data_remainder),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .busy           (busy)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: latency 0 means RDY in the cycle right after the start edge.
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                       output logic [W-1:0] q, output logic [W-1:0] r,
                       output logic e, output int lat);
    longint sa, sb;
    if (b == 0) begin
      q = '0; r = a; e = 1'b1; lat = 0;
    end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = a; r = '0; e = 1'b1; lat = 0;
    end else begin
      if (s) begin
        sa = longint'($signed(a));
        sb = longint'($signed(b));
      end else begin
        sa = longint'({32'd0, a});
        sb = longint'({32'd0, b});
      end
      q = 32'(sa / sb);
      r = 32'(sa % sb);
      e = 1'b0;
      lat = W + 1;
    end
  endtask

  // Drive a start for one edge, then scramble the (don't-care) operands.
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    ctrl_DIV = 1'b1;
    data_operandA = a;
    data_operandB = b;
    ctrl_signed = s;
    @(posedge clock);
    #1;
    ctrl_DIV = 1'b0;
    data_operandA = $urandom;
    data_operandB = $urandom;
    ctrl_signed = 1'($urandom_range(0, 1));
  endtask

  // Called #1 after the start edge; waits for RDY and checks everything.
  task automatic finish_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic s, input logic chk_fall);
    logic [W-1:0] q, r;
    logic e;
    int lat, n;
    model(a, b, s, q, r, e, lat);
    check({tag, ".busy0"}, 64'(busy), 64'(lat != 0));
    n = 0;
    while (!data_resultRDY && n < 200) begin
      @(posedge clock);
      #1;
      n++;
    end
    check({tag, ".lat"}, 64'(n), 64'(lat));
    check({tag, ".q"}, 64'(data_result), 64'(q));
    check({tag, ".r"}, 64'(data_remainder), 64'(r));
    check({tag, ".exc"}, 64'(data_exception), 64'(e));
    check({tag, ".busy_rdy"}, 64'(busy), 64'd0);
    if (chk_fall) begin
      @(posedge clock);
      #1;
      check({tag, ".rdy_fall"}, 64'(data_resultRDY), 64'd0);
      check({tag, ".q_hold"}, 64'(data_result), 64'(q));
    end
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic s);
    start_op(a, b, s);
    finish_op(tag, a, b, s, 1'b1);
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    logic rs;
    int seen;

    // Reset state.
    repeat (3) @(posedge clock);
    #1;
    check("rst.q", 64'(data_result), 64'd0);
    check("rst.r", 64'(data_remainder), 64'd0);
    check("rst.exc", 64'(data_exception), 64'd0);
    check("rst.rdy", 64'(data_resultRDY), 64'd0);
    check("rst.busy", 64'(busy), 64'd0);
    reset = 1'b0;
    @(posedge clock);
    #1;

    // Directed cases.
    run_op("u100_7", 32'd100, 32'd7, 1'b0);
    run_op("s-7_2", 32'hFFFF_FFF9, 32'd2, 1'b1);
    run_op("s7_-2", 32'd7, 32'hFFFF_FFFE, 1'b1);
    run_op("u5_0", 32'd5, 32'd0, 1'b0);
    run_op("s5_0", 32'd5, 32'd0, 1'b1);
    run_op("s_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    run_op("u_min_ones", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_op("s_min_1", 32'h8000_0000, 32'd1, 1'b1);
    run_op("u_big_1", 32'hFFFF_FFFF, 32'd1, 1'b0);

    // Restart at E10: first operation must never signal RDY.
    start_op(32'd100, 32'd7, 1'b0);
    seen = 0;
    repeat (9) begin
      @(posedge clock);
      #1;
      if (data_resultRDY) seen++;
    end
    check("restart.no_rdy", 64'(seen), 64'd0);
    start_op(32'hFFFF_FFFF, 32'h10, 1'b0);
    finish_op("restart", 32'hFFFF_FFFF, 32'h10, 1'b0, 1'b1);

    // New start on the edge where RDY would fall.
    start_op(32'd1000, 32'd9, 1'b0);
    finish_op("b2b_a", 32'd1000, 32'd9, 1'b0, 1'b0);
    start_op(32'hFFFF_FF00, 32'd3, 1'b1);
    finish_op("b2b_b", 32'hFFFF_FF00, 32'd3, 1'b1, 1'b1);

    // Reset at E15 mid-operation.
    start_op(32'd12345, 32'd11, 1'b0);
    repeat (14) @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    check("midrst.q", 64'(data_result), 64'd0);
    check("midrst.r", 64'(data_remainder), 64'd0);
    check("midrst.exc", 64'(data_exception), 64'd0);
    check("midrst.rdy", 64'(data_resultRDY), 64'd0);
    check("midrst.busy", 64'(busy), 64'd0);
    seen = 0;
    repeat (40) begin
      @(posedge clock);
      #1;
      if (data_resultRDY || busy) seen++;
    end
    check("midrst.quiet", 64'(seen), 64'd0);

    // Randomized operations, biased toward the special cases.
    for (int i = 0; i < 24; i++) begin
      ra = $urandom;
      rb = $urandom;
      rs = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 7))
        0: rb = '0;
        1: rb = 32'($urandom_range(1, 20));
        2: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        3: ra = 32'($urandom_range(0, 50));
        default: ;
      endcase
      run_op("rand", ra, rb, rs);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
